iterative_divider: RTL and testbench
====================================

ITERATIVE_DIVIDER -- requirements
Module: iterative_divider

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-003 Port reset_n, input, 1, asynchronous active-low reset.
REQ-004 Port start, input, 1, request a divide; sampled only in IDLE or DONE.
REQ-005 Port is_signed, input, 1, 1 = DIV (two's complement), 0 = DIVU; sampled with start.
REQ-006 Port dividend, input, WIDTH, rs operand (forwarded value from the execute stage); sampled with start.
REQ-007 Port divisor, input, WIDTH, rt operand; sampled with start.
REQ-008 Port abort, input, 1, cancel an in-flight divide (driven by FlushE).
REQ-009 Port busy, output, 1, high in RUN and FIX; stalls the pipeline via the hazard unit.
REQ-010 Port done, output, 1, single-cycle pulse marking hi/lo valid.
REQ-011 Port lo, output, WIDTH, quotient, feeds DivLoE.
REQ-012 Port hi, output, WIDTH, remainder, feeds DivHiE.

Function
REQ-013 FSM states IDLE, RUN, FIX, DONE; exactly one active.
REQ-014 IDLE or DONE with start=1: latch operands, take magnitudes if is_signed, clear counter, go RUN.
REQ-015 RUN: one restoring radix-2 step per cycle for WIDTH cycles, then FIX.
REQ-016 FIX: apply signs (quotient negated if operand signs differ; remainder takes dividend sign), register lo/hi, go DONE.
REQ-017 done high exactly one cycle, in DONE; with default WIDTH it rises exactly 34 cycles after the edge that sampled start.
REQ-018 DONE without start returns to IDLE; DONE with start begins a new divide (back-to-back, no bubble).
REQ-019 start while busy is ignored; operands and result are unaffected.
REQ-020 abort in RUN or FIX returns to IDLE next edge, no done pulse, lo/hi keep their previous values.
REQ-021 abort and start together in IDLE/DONE: abort wins, remain/enter IDLE.
REQ-022 lo/hi hold the last completed result until the next FIX.
REQ-023 Divisor zero: lo = all ones, hi = dividend (unchanged), for both signed and unsigned.
REQ-024 Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
REQ-025 Internal remainder datapath WIDTH+1 bits; no other truncation permitted.

Reset
REQ-026 reset_n low asynchronously forces IDLE, counter 0, busy=0, done=0, lo=0, hi=0.
REQ-027 Reset mid-operation discards the divide; the first start after release behaves as from power-up.

Configuration
REQ-028 Macro DIV_EARLY_OUT_EN: when defined, a start with divisor zero or |dividend| < |divisor| skips RUN/FIX and goes directly to DONE (done on the next cycle), results per REQ-023 or lo=0, hi=dividend.
REQ-029 Without DIV_EARLY_OUT_EN all divides take the full latency of REQ-017; results are identical in both builds.

Structure
REQ-030 Shared package div_pkg holds the state enum, DIV_WIDTH = 32, and DIV_LATENCY = 34.
REQ-031 One combinational sub-module div_step implements a single shift/subtract/restore iteration; iterative_divider instantiates it once.

Verification
REQ-032 DIVU 100/7, start one cycle -> done 34 cycles later, lo=14, hi=2, busy high throughout RUN/FIX.
REQ-033 DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 DIVU 5/0 -> lo=0xFFFFFFFF, hi=5; with DIV_EARLY_OUT_EN done one cycle after start, otherwise after 34.
REQ-035 abort at RUN cycle 10 -> IDLE next edge, no done, lo/hi retain prior result; start 9/3 held high while busy -> ignored.
REQ-036 reset_n pulsed low at RUN cycle 20 -> outputs zero immediately; back-to-back start in DONE -> second result 34 cycles after the first done.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared state type and sizing constants for the iterative divider.
package div_pkg;

    localparam int DIV_WIDTH   = 32;
    // Edges from the one that samples start up to and including the one
    // that enters DONE: 1 latch + DIV_WIDTH steps + 1 sign fix-up.
    localparam int DIV_LATENCY = 34;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one restoring radix-2 iteration (shift in next dividend bit,
// trial-subtract the divisor, keep the difference only if it is non-negative).
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] dvsr_ext;
    // The partial remainder is always below the divisor, so its top bit
    // never carries information into the next shift.
    logic           unused_rem_msb;

    assign unused_rem_msb = rem_i[WIDTH];

    // Shift/compare/restore: quotient bit is 1 when the subtraction fits.
    always_comb begin
        shifted  = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
        dvsr_ext = {1'b0, dvsr_i};
        if (shifted >= dvsr_ext) begin
            rem_o = shifted - dvsr_ext;
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted;
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/iterative_divider.sv
// iterative_divider: multi-cycle signed/unsigned divider for the execute
// stage. Magnitudes are divided with a restoring loop, signs are applied in
// a final fix-up cycle. Optional macro DIV_EARLY_OUT_EN finishes trivial
// divides (divisor zero or |dividend| < |divisor|) one cycle after start.
//
//   state | meaning
//   IDLE  | waiting for start, lo/hi hold last result
//   RUN   | one quotient bit per cycle, WIDTH cycles
//   FIX   | apply signs, register lo/hi
//   DONE  | done pulse; start here chains the next divide
module iterative_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] mag_dividend;
    logic [WIDTH-1:0] mag_divisor;
    logic [WIDTH-1:0] fix_rem;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem),
        .quo_o  (step_quo)
    );

    // Operand magnitudes captured at start; raw values are used for DIVU.
    always_comb begin
        mag_dividend = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        mag_divisor  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
        fix_rem      = rem_q[WIDTH-1:0];
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    rem_d     = '0;
                    quo_d     = mag_dividend;
                    dvsr_d    = mag_divisor;
                    cnt_d     = '0;
                    neg_quo_d = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d = is_signed && dividend[WIDTH-1];
                    dz_d      = (divisor == '0);
`ifdef DIV_EARLY_OUT_EN
                    if ((divisor == '0) || (mag_dividend < mag_divisor)) begin
                        lo_d    = (divisor == '0) ? '1 : '0;
                        hi_d    = dividend;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
`else
                    state_d = S_RUN;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    // Divide by zero: the loop already leaves the dividend as
                    // remainder; only the quotient needs forcing to all ones.
                    lo_d    = dz_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
                    hi_d    = neg_rem_q ? -fix_rem : fix_rem;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end

    assign busy = (state_q == S_RUN) || (state_q == S_FIX);
    assign done = (state_q == S_DONE);
    assign lo   = lo_q;
    assign hi   = hi_q;

endmodule

// File: tb/tb_iterative_divider.sv
// tb_iterative_divider: directed and random divides against a plain
// arithmetic reference, plus abort, ignored-start, back-to-back and
// mid-operation reset scenarios.
module tb_iterative_divider;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] lo;
    logic [31:0] hi;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_lo = '0;
    logic [31:0] exp_hi = '0;

    iterative_divider #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .lo        (lo),
        .hi        (hi)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {quotient, remainder} from plain integer arithmetic.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (!sgn) return {a / b, a % b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = 32'(sa / sb);
        r  = 32'(sa % sb);
        return {q, r};
    endfunction

    // Edges from the sampling edge (counted as 1) to the one entering DONE.
    function automatic int ref_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        longint ma, mb;
        ma = (sgn && a[31]) ? -longint'($signed(a)) : longint'({32'd0, a});
        mb = (sgn && b[31]) ? -longint'($signed(b)) : longint'({32'd0, b});
        if (b == 32'd0 || ma < mb) return 1;
`else
        if (sgn && a == b) return 34;
`endif
        return 34;
    endfunction

    // Present operands, let one edge sample them, then drop start.
    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Called 1 time unit after the sampling edge; bounded wait for done.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 200) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] e;
        int          lat;
        int          elat;
        bit          bok;
        e    = ref_div(sgn, a, b);
        elat = ref_lat(sgn, a, b);
        launch(sgn, a, b);
        wait_done(lat, bok);
        check({tag, "_lat"}, 64'(lat), 64'(elat));
        check({tag, "_lo"}, 64'(lo), 64'(e[63:32]));
        check({tag, "_hi"}, 64'(hi), 64'(e[31:0]));
        if (elat > 1) check({tag, "_busy"}, 64'(bok), 64'(1));
        exp_lo = e[63:32];
        exp_hi = e[31:0];
        @(posedge clock);
        #1;
        check({tag, "_pulse"}, 64'(done), 64'(0));
        check({tag, "_idle"}, 64'(busy), 64'(0));
    endtask

    initial begin
        logic [63:0] e;
        logic [31:0] ra, rb;
        logic        rs;
        int          lat;
        bit          bok;
        bit          saw_done;

        // Reset state
        #2;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        #10 reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Directed divides
        do_div(1'b0, 32'd100, 32'd7, "divu_100_7");
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        do_div(1'b0, 32'd5, 32'd0, "divu_5_0");
        do_div(1'b1, 32'hFFFF_FFFB, 32'd0, "div_m5_0");
        do_div(1'b1, 32'd3, 32'hFFFF_FFF9, "div_3_m7");
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1");

        // Random divides
        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = $urandom;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'd0 - 32'($urandom_range(1, 15));
                3:       rb = 32'd0;
                default: begin rb = $urandom; ra = 32'($urandom_range(0, 100)); end
            endcase
            do_div(rs, ra, rb, $sformatf("rand%0d", i));
        end

        // start held high while busy is ignored; then chains back-to-back
        e = ref_div(1'b0, 32'hFFFF_0000, 32'd3);
        launch(1'b0, 32'hFFFF_0000, 32'd3);
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd9;
        divisor   = 32'd3;
        wait_done(lat, bok);
        check("hold_lat", 64'(lat), 64'(34));
        check("hold_busy", 64'(bok), 64'(1));
        check("hold_lo", 64'(lo), 64'(e[63:32]));
        check("hold_hi", 64'(hi), 64'(e[31:0]));
        @(posedge clock);
        #1;
        start = 1'b0;
        check("b2b_nobubble", 64'(busy), 64'(1));
        wait_done(lat, bok);
        check("b2b_lat", 64'(lat), 64'(34));
        check("b2b_lo", 64'(lo), 64'(3));
        check("b2b_hi", 64'(hi), 64'(0));
        exp_lo = 32'd3;
        exp_hi = 32'd0;
        @(posedge clock);
        #1;

        // Abort at RUN cycle 10
        launch(1'b0, 32'h7654_3210, 32'd5);
        repeat (9) @(posedge clock);
        #1;
        check("abort_running", 64'(busy), 64'(1));
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_lo", 64'(lo), 64'(exp_lo));
        check("abort_hi", 64'(hi), 64'(exp_hi));
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            @(posedge clock);
            #1;
        end
        check("abort_nodone", 64'(saw_done), 64'(0));

        // abort together with start in IDLE keeps IDLE
        start     = 1'b1;
        abort     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd50;
        divisor   = 32'd5;
        @(posedge clock);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_busy", 64'(busy), 64'(0));
        check("abort_start_done", 64'(done), 64'(0));
        check("abort_start_lo", 64'(lo), 64'(exp_lo));

        // Asynchronous reset at RUN cycle 20
        launch(1'b1, 32'h8765_4321, 32'd77);
        repeat (19) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_lo", 64'(lo), 64'(0));
        check("midrst_hi", 64'(hi), 64'(0));
        #2;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        do_div(1'b1, 32'hFFFF_FF9C, 32'd7, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
